// File: rtl/load_store_unit.sv
// Load/store unit: core request -> word-aligned bus transaction with byte enables, load extension.
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_busy,
  output logic        lsu_exc,
  output logic        lsu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, EXC} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3_lat;
  logic [1:0]  addr_lo;
  logic        legal, aligned, abort;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be within 1..255");
  end

  always_comb begin
    legal = 1'b0;
    case (lsu_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !lsu_we;
      default:                legal = 1'b0;
    endcase
    aligned = !((lsu_funct3[1:0] == 2'b01 && lsu_addr[0]) ||
                (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00));
    case (lsu_funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << lsu_addr[1:0];
        wdata_new = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{lsu_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = lsu_wdata;
      end
    endcase
  end

  // Lane select uses the offset latched at acceptance; word loads are always at offset 0.
  always_comb begin
    load_byte = mem_rdata[8*addr_lo +: 8];
    load_half = mem_rdata[16*addr_lo[1] +: 16];
    case (funct3_lat)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (lsu_req) next_state = (legal && aligned) ? BUS : EXC;
      BUS:  if (mem_ack || abort) next_state = RESP;
      RESP: next_state = IDLE;
      EXC:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      funct3_lat <= 3'b000;
      addr_lo    <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
      lsu_rdata  <= 32'h0;
      lsu_done   <= 1'b0;
      lsu_exc    <= 1'b0;
    end else begin
      lsu_done <= (next_state == RESP) || (next_state == EXC);
      lsu_exc  <= (next_state == EXC);
      if (state == IDLE && next_state == BUS) begin
        funct3_lat <= lsu_funct3;
        addr_lo    <= lsu_addr[1:0];
        mem_req    <= 1'b1;
        mem_we     <= lsu_we;
        mem_addr   <= {lsu_addr[31:2], 2'b00};
        mem_be     <= be_new;
        mem_wdata  <= wdata_new;
      end
      if (state == BUS && next_state == RESP) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        // Ack takes priority over a simultaneous timeout.
        if (mem_ack && !mem_we) lsu_rdata <= load_data;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign abort = (state == BUS) && !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 8'h0;
      lsu_fault <= 1'b0;
    end else begin
      lsu_fault <= abort;
      if (state != BUS)  wait_cnt <= 8'h0;
      else if (!mem_ack) wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign abort     = 1'b0;
  assign lsu_fault = 1'b0;
`endif

  // Combinational so the PC stalls in the request cycle itself; forced low during reset.
  assign lsu_busy = rst && ((state != IDLE) || lsu_req);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised self-checking bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst, lsu_req, lsu_we, mem_ack;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        lsu_done, lsu_busy, lsu_exc, lsu_fault, mem_req, mem_we;
  logic [3:0]  mem_be;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rdata = 32'h0;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
    .lsu_busy(lsu_busy), .lsu_exc(lsu_exc), .lsu_fault(lsu_fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic bit m_exc(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      return 1'b1;
    size = 1 << f3[1:0];
    return (a % size) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << f3[1:0];
    return 4'(((1 << size) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (1 << f3[1:0])
      1:       return {24'h0, w[7:0]} * 32'h01010101;
      2:       return {16'h0, w[15:0]} * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v, mask;
    int size;
    size = 1 << f3[1:0];
    mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = (r >> (8 * (a % 4))) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  // One access starting the cycle after the call; ack_at=0 means the bus never acks.
  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] w, input logic [31:0] r, input int ack_at,
                           input string nm);
    bit exc, fault;
    int last;
    logic [69:0] got, want;
    exc   = m_exc(we, f3, a);
    fault = (ack_at == 0);
    last  = fault ? TMO : ack_at;
    want  = {1'b1, we, a & ~32'd3, m_be(f3, a), we ? m_wdata(f3, w) : 32'h0};
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = w;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    #1;
    total++;
    if (lsu_busy !== 1'b1) begin
      bad++; $display("FAIL %s req_busy got=%b want=1", nm, lsu_busy);
    end
    for (int cyc = 1; cyc <= (exc ? 1 : last + 1); cyc++) begin
      @(posedge clk); #1;
      if (exc || cyc > last) mem_ack = 1'($urandom % 2);
      else                   mem_ack = (cyc == ack_at);
      mem_rdata = (!exc && cyc == ack_at) ? r : $urandom;
      #1;
      if (exc || cyc == last + 1) begin
        if (!exc && !we && !fault) exp_rdata = m_load(f3, a, r);
        total++;
        if ({lsu_done, lsu_exc, lsu_fault, mem_req, lsu_busy, lsu_rdata} !==
            {1'b1, exc, fault, 1'b0, 1'b1, exp_rdata}) begin
          bad++;
          $display("FAIL %s done_cyc%0d done/exc/fault/req/busy/rdata got=%b%b%b%b%b/%h want=%b%b%b01/%h",
                   nm, cyc, lsu_done, lsu_exc, lsu_fault, mem_req, lsu_busy, lsu_rdata,
                   1'b1, exc, fault, exp_rdata);
        end
        lsu_req = 1'b0;
      end else begin
        got = {mem_req, mem_we, mem_addr, mem_be, we ? mem_wdata : 32'h0};
        total++;
        if (got !== want) begin
          bad++; $display("FAIL %s bus_cyc%0d req/we/addr/be/wdata got=%h want=%h", nm, cyc, got, want);
        end
        total++;
        if ({lsu_done, lsu_busy} !== 2'b01) begin
          bad++; $display("FAIL %s wait_cyc%0d done/busy got=%b%b want=01", nm, cyc, lsu_done, lsu_busy);
        end
      end
    end
    mem_ack = 1'b0;
    $display("txn %s we=%0b f3=%0d addr=%h exc=%0b fault=%0b rdata=%h", nm, we, f3, a, exc, fault, lsu_rdata);
  endtask

  task automatic test_reset();
    rst = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = 32'h0;
    lsu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({lsu_rdata, lsu_done, lsu_busy, lsu_exc, lsu_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs rdata=%h done=%b busy=%b req=%b be=%h want all zero",
                      lsu_rdata, lsu_done, lsu_busy, mem_req, mem_be);
    end
    rst = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_spec_cases();
    do_access(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 3, "sw_ack2");
    do_access(1'b0, 3'b000, 32'h43, 32'h0, 32'h80FF1234, 1, "lb_43");
    do_access(1'b0, 3'b100, 32'h43, 32'h0, 32'h80FF1234, 1, "lbu_43");
    do_access(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 1, "sh_22");
    do_access(1'b0, 3'b101, 32'h22, 32'h0, 32'h9234_5678, 2, "lhu_22");
    do_access(1'b0, 3'b001, 32'h22, 32'h0, 32'h9234_5678, 1, "lh_22");
  endtask

  task automatic test_exceptions();
    do_access(1'b0, 3'b010, 32'h41, 32'h0, 32'h0, 1, "lw_mis");
    do_access(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1, "lh_mis");
    do_access(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1, "ld_f3_011");
    do_access(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 1, "st_f3_100");
    do_access(1'b1, 3'b010, 32'h42, 32'h1, 32'h0, 1, "sw_mis");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      a  = $urandom;
      if ($urandom % 4 != 0) a = a & ~32'((1 << f3[1:0]) - 1);
      do_access(we, f3, a, $urandom, $urandom, int'($urandom_range(1, 4)), "rand");
    end
  endtask

  task automatic test_mid_reset();
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 1, "lw_pre");
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h80; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL midrst_inbus mem_req got=%b want=1", mem_req);
    end
    rst = 1'b0;
    #1;
    exp_rdata = 32'h0;
    total++;
    if ({mem_req, lsu_busy, lsu_done, lsu_rdata, mem_be} !== '0) begin
      bad++; $display("FAIL midrst_drop req=%b busy=%b done=%b rdata=%h be=%h want all zero",
                      mem_req, lsu_busy, lsu_done, lsu_rdata, mem_be);
    end
    @(posedge clk); #2;
    rst = 1'b1; lsu_req = 1'b0;
    $display("txn mid-transaction reset");
    do_access(1'b0, 3'b010, 32'h84, 32'h0, 32'hCAFE_F00D, 2, "lw_post");
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    do_access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 0, "lw_tmo");
    do_access(1'b1, 3'b000, 32'h201, 32'h55, 32'h0, 0, "sb_tmo");
    do_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h7F00_0000, 4, "lb_ack_at_tmo");
  endtask
`endif

  initial begin
    test_reset();
    test_spec_cases();
    test_exceptions();
    test_back_to_back();
    test_mid_reset();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the ALU and data memory. It turns a core load or store request into a word-aligned memory bus transaction with byte enables and a valid/acknowledge handshake, and sign- or zero-extends load data for the register write-back mux. Because memory latency is variable, it drives a busy signal that stalls the program counter.

## Interface
- `TIMEOUT`, default 255: bus cycles to wait for `mem_ack` before aborting. Range 1–255, 8-bit counter. Used only with `LSU_TIMEOUT_EN`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `lsu_req` in 1: core request. Held high until `lsu_done`.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_funct3` in 3: width/sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `lsu_addr` in 32: byte address (ALU result).
- `lsu_wdata` in 32: store data (rs2).
- `lsu_rdata` out 32: extended load data, registered.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_busy` out 1: stall request to the PC and register-file write enable.
- `lsu_exc` out 1: misaligned or illegal access. Valid only in the cycle `lsu_done`=1.
- `lsu_fault` out 1: bus timeout. Valid only in the cycle `lsu_done`=1.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: `{lsu_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus acknowledge. For reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: bus read word.

## Operation
- **FSM states:** IDLE, BUS, RESP, EXC.
- **IDLE**
  - `lsu_req`=1 with a legal, aligned access: latch `we`, `funct3`, `addr[1:0]`, `mem_addr`, `mem_be`, `mem_wdata`, then go to BUS.
  - Misaligned access or illegal `funct3`: go to EXC.
- **Legality and alignment**
  - Illegal `funct3`: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
  - Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
- **BUS**
  - `mem_req`=1; all `mem_*` outputs stay stable until `mem_ack`.
  - On `mem_ack`: for a load, capture the extended `mem_rdata` into `lsu_rdata`; go to RESP.
- **RESP:** `lsu_done`=1, then IDLE.
- **EXC:** `lsu_done`=1, `lsu_exc`=1, then IDLE. No bus access is issued.
- **Byte enables and store data**
  - Byte: `mem_be`=`4'b0001<<addr[1:0]`; `mem_wdata`=`{4{wdata[7:0]}}`.
  - Half: `mem_be`=`addr[1]?4'b1100:4'b0011`; `mem_wdata`=`{2{wdata[15:0]}}`.
  - Word: `mem_be`=`4'b1111`; `mem_wdata`=`wdata`.
  - For loads, `mem_be` uses the same encoding; `mem_we`=0.
- **Load extraction**
  - Select the byte or half at `addr[1:0]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- **`lsu_rdata` hold:** holds its value until the next successful load. Stores, exceptions and faults leave it unchanged.
- **`lsu_busy`** = (state≠IDLE) | (IDLE & `lsu_req`). This is combinational so the PC stalls in the request cycle itself.
- **Request after completion:** `lsu_req` is ignored in RESP and EXC. A new request is accepted at the earliest in the cycle after `lsu_done`.
- **`mem_ack` outside BUS:** ignored.

## Timing
- **Reset:** asynchronous assertion forces IDLE immediately. All outputs go to 0, including `lsu_rdata`=0 and `mem_req`=0, and any in-flight bus request is dropped. Deassertion is synchronised externally.
- **Latency**
  - Request accepted at edge 0.
  - `mem_req` high from cycle 1.
  - Ack in cycle k gives `lsu_done` in cycle k+1.
  - Minimum 3 cycles, request to done inclusive (ack in cycle 1).
- **Exception path:** `lsu_done`/`lsu_exc` in cycle 1.
- **Registered outputs:** all `mem_*` outputs, `lsu_done`, `lsu_exc`, `lsu_fault` and `lsu_rdata` are registered.

## Configuration
- **`LSU_TIMEOUT_EN` defined**
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches `TIMEOUT`, the request is aborted: `mem_req`=0 next cycle, state goes to RESP with `lsu_fault`=1, and `lsu_rdata` is unchanged.
  - An ack in the same cycle as the timeout wins (normal completion).
- **`LSU_TIMEOUT_EN` undefined:** no counter; BUS waits indefinitely; `lsu_fault` is tied to 0.

## Test plan
- **SW, ack after 2 cycles:** `addr`=0x40, `wdata`=0xDEADBEEF, ack after 2 bus cycles -> `mem_addr`=0x40, `mem_be`=1111, `mem_we`=1, `lsu_done` 4 cycles after request, `lsu_busy` high throughout.
- **LB then LBU, immediate ack:** `addr`=0x43, `mem_rdata`=0x80FF1234 -> LB gives `lsu_rdata`=0xFFFFFF80; LBU gives 0x00000080; `mem_be`=1000.
- **SH to upper half:** `addr`=0x22, `wdata`=0x0000ABCD -> `mem_addr`=0x20, `mem_be`=1100, `mem_wdata`=0xABCDABCD.
- **Misaligned and illegal accesses:** LW at 0x41 -> `lsu_done` and `lsu_exc` in cycle 1, `mem_req` never asserted. Repeat for LH at 0x13 and for `funct3`=011.
- **Reset mid-transaction:** `rst` low during BUS -> `mem_req` and `lsu_busy` drop at once, state is IDLE, and a new LW after release completes normally.
- **Timeout:** with `LSU_TIMEOUT_EN` and `TIMEOUT`=4, no ack -> `mem_req` high for 4 cycles, then `lsu_done`=`lsu_fault`=1 and `lsu_rdata` unchanged.
